r_pipe: RTL and testbench
=========================

# r_pipe

Parametrised two-stage R-type execute pipeline: a multi-ported register file, an ALU with registered flags, and a result/writeback register with valid/ready handshakes on both sides. It sits between instruction decode, which issues register-register or register-immediate operations, and any downstream result consumer. Results commit to the register file only when the consumer accepts them. A write-to-read bypass lets dependent operations issue back-to-back without stalling.

## Interface
- XLEN, 32: datapath width; power of two, at least 8.
- NREG, 32: number of registers; power of two; register 0 is hardwired to zero.
- AW, $clog2(NREG): register address width (derived).
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  issue request.
- in_ready  out  1  issue accepted when in_valid && in_ready.
- op  in  4  operation code (see Operation).
- rs1, rs2, rd  in  AW  source and destination register indices.
- use_imm  in  1  1 selects imm as operand B instead of reg[rs2].
- imm  in  XLEN  immediate operand.
- out_valid  out  1  result register holds an uncommitted result.
- out_ready  in  1  consumer accepts the result; this is also the commit strobe.
- out_rd  out  AW  destination of the held result.
- out_result  out  XLEN  held result.
- out_zero, out_carry, out_ovf, out_err  out  1  flags for the held result.
- dbg_addr  in  AW  debug read index.
- dbg_data  out  XLEN  combinational read of the architectural register; not bypassed.

## Operation
- Opcodes:
  - 0 ADD; 1 SUB; 2 AND; 3 OR; 4 XOR; 5 NOR.
  - 6 SLL; 7 SRL; 8 SRA. Shift amount is b[$clog2(XLEN)-1:0].
  - 9 SLT (signed); 10 SLTU. Both return 1 or 0, zero-extended.
  - 11–15 illegal: result 0, err=1.
- Operand A is reg[rs1]. Operand B is imm if use_imm, otherwise reg[rs2]. Any index of 0 reads 0.
- Bypass: if out_valid && out_rd==rsN && rsN!=0, operand N takes out_result instead of the register file.
- Flags:
  - zero: result==0.
  - carry: carry-out of ADD; for SUB, carry = 1 means no borrow. 0 for all other ops.
  - ovf: signed overflow for ADD/SUB only.
- Issue: on acceptance, the result register loads the ALU output, rd, and the flags, and out_valid sets.
- Commit: on out_valid && out_ready, reg[out_rd] <= out_result, unless out_rd==0 or out_err. out_valid then clears unless a new issue is accepted in the same cycle.
- in_ready = !out_valid || out_ready (single-entry skid-free pipeline).
- Reset:
  - All registers reset to 0.
  - out_valid, out_rd, out_result and all flags reset to 0.
  - An uncommitted result is discarded.

## Timing
- Latency: an issue accepted at edge N has out_valid high after edge N and is committable at edge N+1 at the earliest.
- Throughput: one operation per cycle while out_ready stays high.
- Back-to-back dependent issue: the operand sees the bypassed value while the producer commits at the same edge, so there is no bubble.
- Backpressure: while out_valid && !out_ready:
  - out_* is held stable.
  - in_ready=0.
  - The register file is unchanged.
- Simultaneous commit and issue: the commit write and the result-register load happen at the same edge. The new result replaces the old one.
- Asynchronous reset mid-stall: out_valid falls immediately, with no clock required. The held result is never written.
- dbg_data reflects a commit in the cycle after the commit edge.

## Structure
- r_pipe_pkg holds:
  - the op enum and its encodings (OP_ADD…OP_SLTU);
  - the OP_W=4 constant;
  - an alu_flags_t struct (zero, carry, ovf, err).
- The sub-module r_alu is purely combinational. Inputs: a, b, op. Outputs: result and alu_flags_t. It is parametrised by XLEN.
- Everything else lives in r_pipe: register file, bypass mux, result register, handshake logic.

## Test plan
- Reset: assert rst_n=0 mid-run, release, sweep dbg_addr 0..31 -> every read returns 0; out_valid=0, in_ready=1.
- Dependency chain:
  - Issue ADD x1=x0+imm 5, then ADD x2=x1+x1, then SUB x3=x2-imm 7 on consecutive cycles with out_ready=1.
  - Required results: out_result 5, then 10, then 3.
  - dbg shows x1=5, x2=10, x3=3; no stall cycles occur.
- Backpressure:
  - Issue ADD x4=x0+imm 9 with out_ready=0 for 3 cycles.
  - While stalled: out_valid=1, out_result=9 stable, in_ready=0, dbg x4=0.
  - Raise out_ready: x4=9 the next cycle.
- Flags:
  - ADD 0x7FFFFFFF+1 -> result 0x80000000, ovf=1, carry=0.
  - SUB 5-7 -> 0xFFFFFFFE, carry=0, ovf=0.
  - SUB 7-7 -> zero=1, carry=1.
- x0 and illegal ops:
  - ADD x0=x0+imm 3 -> out_result=3, yet x0 still reads 0, and a following ADD x1=x0+x0 returns 0 with no bypass.
  - op=15 -> out_err=1, result 0, destination unchanged.
- Reset during stall: hold a pending ADD x5=x0+imm 1 with out_ready=0, then pulse rst_n low between edges -> out_valid drops at once and x5 stays 0.

Source files
------------

// File: rtl/r_pipe_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | r_pipe_pkg : opcodes, flag bundle and widths for r_pipe         |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
package r_pipe_pkg;

  localparam int OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_NOR  = 4'd5,
    OP_SLL  = 4'd6,
    OP_SRL  = 4'd7,
    OP_SRA  = 4'd8,
    OP_SLT  = 4'd9,
    OP_SLTU = 4'd10
  } op_e;

  typedef struct packed {
    logic zero;
    logic carry;
    logic ovf;
    logic err;
  } alu_flags_t;

endpackage
`default_nettype wire

// File: rtl/r_alu.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | r_alu : combinational R-type ALU with zero/carry/ovf/err flags  |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module r_alu
  import r_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [OP_W-1:0] op,
  output logic [XLEN-1:0] result,
  output alu_flags_t      flags
);

  localparam int SHW = $clog2(XLEN);

  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_diff;
  logic [SHW-1:0]  w_sh;

  assign w_sum  = {1'b0, a} + {1'b0, b};
  // a + ~b + 1: the extra bit is 1 exactly when no borrow occurred
  assign w_diff = {1'b0, a} + {1'b0, ~b} + {{XLEN{1'b0}}, 1'b1};
  assign w_sh   = b[SHW-1:0];

  always_comb begin
    result = '0;
    flags  = '0;
    case (op)
      OP_ADD: begin
        result      = w_sum[XLEN-1:0];
        flags.carry = w_sum[XLEN];
        flags.ovf   = (a[XLEN-1] == b[XLEN-1]) && (w_sum[XLEN-1] != a[XLEN-1]);
      end
      OP_SUB: begin
        result      = w_diff[XLEN-1:0];
        flags.carry = w_diff[XLEN];
        flags.ovf   = (a[XLEN-1] != b[XLEN-1]) && (w_diff[XLEN-1] != a[XLEN-1]);
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOR:  result = ~(a | b);
      OP_SLL:  result = a << w_sh;
      OP_SRL:  result = a >> w_sh;
      OP_SRA:  result = $unsigned($signed(a) >>> w_sh);
      OP_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
      default: flags.err = 1'b1;
    endcase
    flags.zero = (result == '0);
  end

endmodule
`default_nettype wire

// File: rtl/r_pipe.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | r_pipe : register file + ALU + result register, commit-on-accept|
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module r_pipe
  import r_pipe_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OP_W-1:0] op,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  input  logic [AW-1:0]   rd,
  input  logic            use_imm,
  input  logic [XLEN-1:0] imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [AW-1:0]   out_rd,
  output logic [XLEN-1:0] out_result,
  output logic            out_zero,
  output logic            out_carry,
  output logic            out_ovf,
  output logic            out_err,
  input  logic [AW-1:0]   dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  logic                       r_valid;
  logic [AW-1:0]              r_rd;
  logic [XLEN-1:0]            r_result;
  alu_flags_t                 r_flags;

  logic [NREG-1:0][XLEN-1:0]  w_rf;
  logic                       w_issue;
  logic                       w_retire;
  logic                       w_commit;
  logic [XLEN-1:0]            w_a;
  logic [XLEN-1:0]            w_rs2_val;
  logic [XLEN-1:0]            w_b;
  logic [XLEN-1:0]            w_alu_res;
  alu_flags_t                 w_alu_flags;

  assign in_ready = !r_valid || out_ready;
  assign w_issue  = in_valid && in_ready;
  assign w_retire = r_valid && out_ready;
  // Writes to x0 are dropped because entry 0 has no storage
  assign w_commit = w_retire && !r_flags.err;

  for (genvar i = 0; i < NREG; i++) begin : g_regs
    if (i == 0) begin : g_zero
      assign w_rf[i] = '0;
    end else begin : g_reg
      logic [XLEN-1:0] r_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_q <= '0;
        end else if (w_commit && (r_rd == AW'(i))) begin
          r_q <= r_result;
        end
      end
      assign w_rf[i] = r_q;
    end
  end

  // The held result is the newest value of its destination
  always_comb begin
    w_a = w_rf[rs1];
    if (r_valid && (r_rd == rs1) && (rs1 != '0)) w_a = r_result;
    w_rs2_val = w_rf[rs2];
    if (r_valid && (r_rd == rs2) && (rs2 != '0)) w_rs2_val = r_result;
  end

  assign w_b = use_imm ? imm : w_rs2_val;

  r_alu #(
    .XLEN (XLEN)
  ) u_alu (
    .a      (w_a),
    .b      (w_b),
    .op     (op),
    .result (w_alu_res),
    .flags  (w_alu_flags)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= 1'b0;
      r_rd     <= '0;
      r_result <= '0;
      r_flags  <= '0;
    end else if (w_issue) begin
      r_valid  <= 1'b1;
      r_rd     <= rd;
      r_result <= w_alu_res;
      r_flags  <= w_alu_flags;
    end else if (w_retire) begin
      r_valid  <= 1'b0;
    end
  end

  assign out_valid  = r_valid;
  assign out_rd     = r_rd;
  assign out_result = r_result;
  assign out_zero   = r_flags.zero;
  assign out_carry  = r_flags.carry;
  assign out_ovf    = r_flags.ovf;
  assign out_err    = r_flags.err;
  assign dbg_data   = w_rf[dbg_addr];

endmodule
`default_nettype wire

// File: tb/tb_r_pipe.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_r_pipe : directed bench with a cycle-level reference model   |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module tb_r_pipe;

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  typedef struct packed {
    logic [31:0] res;
    logic        z;
    logic        c;
    logic        o;
    logic        e;
  } res_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [4:0]  rs1, rs2, rd;
  logic        use_imm;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_rd;
  logic [31:0] out_result;
  logic        out_zero, out_carry, out_ovf, out_err;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  int n_pass  = 0;
  int n_total = 0;

  r_pipe #(.XLEN(32), .NREG(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .rs1        (rs1),
    .rs2        (rs2),
    .rd         (rd),
    .use_imm    (use_imm),
    .imm        (imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_rd     (out_rd),
    .out_result (out_result),
    .out_zero   (out_zero),
    .out_carry  (out_carry),
    .out_ovf    (out_ovf),
    .out_err    (out_err),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: architectural registers plus one pending result
  logic [31:0] m_rf [32];
  logic        m_v;
  logic [4:0]  m_rd;
  res_t        m_out;
  logic [31:0] m_a, m_b;
  logic        m_com, m_iss;

  function automatic res_t model_alu(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    res_t   r;
    longint sa, sb, s;
    r  = '0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      4'd0: begin
        r.res = a + b;
        r.c   = ({32'd0, a} + {32'd0, b}) > 64'hFFFF_FFFF;
        s     = sa + sb;
        r.o   = (s > SMAX) || (s < SMIN);
      end
      4'd1: begin
        r.res = a - b;
        r.c   = (a >= b);
        s     = sa - sb;
        r.o   = (s > SMAX) || (s < SMIN);
      end
      4'd2:  r.res = a & b;
      4'd3:  r.res = a | b;
      4'd4:  r.res = a ^ b;
      4'd5:  r.res = ~(a | b);
      4'd6:  r.res = a << b[4:0];
      4'd7:  r.res = a >> b[4:0];
      4'd8:  r.res = $signed(a) >>> b[4:0];
      4'd9:  r.res = (sa < sb) ? 32'd1 : 32'd0;
      4'd10: r.res = (a < b) ? 32'd1 : 32'd0;
      default: r.e = 1'b1;
    endcase
    r.z = (r.res == 32'd0);
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    m_v   = 1'b0;
    m_rd  = 5'd0;
    m_out = '0;
  endtask

  always @(negedge rst_n) model_clear();

  always @(posedge clk) begin
    if (rst_n) begin
      m_com = m_v && out_ready;
      m_iss = in_valid && (!m_v || out_ready);
      m_a = (rs1 == 5'd0) ? 32'd0 : (m_v && m_rd == rs1) ? m_out.res : m_rf[rs1];
      m_b = (rs2 == 5'd0) ? 32'd0 : (m_v && m_rd == rs2) ? m_out.res : m_rf[rs2];
      if (use_imm) m_b = imm;
      if (m_com && m_rd != 5'd0 && !m_out.e) m_rf[m_rd] = m_out.res;
      if (m_iss) begin
        m_v   = 1'b1;
        m_rd  = rd;
        m_out = model_alu(op, m_a, m_b);
      end else if (m_com) begin
        m_v = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", in_ready, !m_v || out_ready);
      chk("out_valid", out_valid, m_v);
      if (m_v) begin
        chk("out_rd", out_rd, m_rd);
        chk("out_result", out_result, m_out.res);
        chk("flags", {out_zero, out_carry, out_ovf, out_err}, {m_out.z, m_out.c, m_out.o, m_out.e});
      end
      chk("dbg_data", dbg_data, m_rf[dbg_addr]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] o, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [4:0] d, input logic ui, input logic [31:0] im);
    in_valid = 1'b1;
    op       = o;
    rs1      = s1;
    rs2      = s2;
    rd       = d;
    use_imm  = ui;
    imm      = im;
  endtask

  task automatic peek(input logic [4:0] a, input logic [31:0] exp, input string nm);
    dbg_addr = a;
    #1;
    chk(nm, dbg_data, exp);
  endtask

  initial begin
    model_clear();
    rst_n = 1'b0; in_valid = 1'b0; op = 4'd0; rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
    use_imm = 1'b0; imm = 32'd0; out_ready = 1'b1; dbg_addr = 5'd0;
    repeat (2) step();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    rst_n = 1'b1;
    step();

    // Dependency chain through the bypass
    drive(4'd0, 5'd0, 5'd0, 5'd1, 1'b1, 32'd5); step();
    chk("chain_x1", out_result, 32'd5);
    drive(4'd0, 5'd1, 5'd1, 5'd2, 1'b0, 32'd0);
    chk("chain_nostall", in_ready, 1'b1);
    step();
    chk("chain_x2", out_result, 32'd10);
    drive(4'd1, 5'd2, 5'd0, 5'd3, 1'b1, 32'd7); step();
    chk("chain_x3", out_result, 32'd3);
    in_valid = 1'b0; step();
    peek(5'd1, 32'd5, "dbg_x1");
    peek(5'd2, 32'd10, "dbg_x2");
    peek(5'd3, 32'd3, "dbg_x3");

    // Backpressure
    out_ready = 1'b0;
    drive(4'd0, 5'd0, 5'd0, 5'd4, 1'b1, 32'd9); step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_result", out_result, 32'd9);
      chk("bp_in_ready", in_ready, 1'b0);
      peek(5'd4, 32'd0, "bp_dbg_x4");
      step();
    end
    out_ready = 1'b1; step();
    peek(5'd4, 32'd9, "bp_commit_x4");

    // Flags
    drive(4'd0, 5'd0, 5'd0, 5'd6, 1'b1, 32'h7FFF_FFFF); step();
    drive(4'd0, 5'd6, 5'd0, 5'd7, 1'b1, 32'd1); step();
    chk("ovf_result", out_result, 32'h8000_0000);
    chk("ovf_flags", {out_ovf, out_carry}, 2'b10);
    drive(4'd1, 5'd1, 5'd0, 5'd8, 1'b1, 32'd7); step();
    chk("sub_neg_result", out_result, 32'hFFFF_FFFE);
    chk("sub_neg_flags", {out_carry, out_ovf}, 2'b00);
    drive(4'd0, 5'd0, 5'd0, 5'd9, 1'b1, 32'd7); step();
    drive(4'd1, 5'd9, 5'd0, 5'd10, 1'b1, 32'd7); step();
    chk("sub_eq_flags", {out_zero, out_carry}, 2'b11);

    // Remaining ops on a negative operand (x8 = -2)
    for (int o = 2; o <= 10; o++) begin
      drive(4'(o), 5'd8, 5'd0, 5'd12, 1'b1, 32'd1); step();
      if (o == 8) chk("sra_neg", out_result, 32'hFFFF_FFFF);
      if (o == 9) chk("slt_neg", out_result, 32'd1);
    end

    // x0 writes are dropped and never bypassed
    drive(4'd0, 5'd0, 5'd0, 5'd0, 1'b1, 32'd3); step();
    chk("x0_result", out_result, 32'd3);
    drive(4'd0, 5'd0, 5'd0, 5'd1, 1'b0, 32'd0); step();
    chk("x0_nobypass", out_result, 32'd0);
    in_valid = 1'b0; step();
    peek(5'd0, 32'd0, "x0_reads_zero");

    // Illegal opcode
    drive(4'd15, 5'd2, 5'd0, 5'd11, 1'b1, 32'd1); step();
    chk("illegal_err", out_err, 1'b1);
    chk("illegal_result", out_result, 32'd0);
    in_valid = 1'b0; step();
    peek(5'd11, 32'd0, "illegal_no_write");

    // Asynchronous reset while stalled
    out_ready = 1'b0;
    drive(4'd0, 5'd0, 5'd0, 5'd5, 1'b1, 32'd1); step();
    in_valid = 1'b0;
    chk("stall_pending", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 1'b0);
    chk("async_rst_in_ready", in_ready, 1'b1);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      step();
      chk("rst_sweep", dbg_data, 32'd0);
    end
    chk("rst_sweep_valid", out_valid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
